fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined ARM core; sits directly upstream of the hazard detection unit and consumes its hazard/freeze signal.
- Owns the PC and runs a request/ready handshake to instruction memory with variable latency.
- Holds the current instruction on hazard, flushes on taken branch, and presents {PC+4, instruction, valid} to the decode stage.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/if_id_register.sv | 43 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM states and shared constants for the fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {
    FS_FETCH   = 2'd0,
    FS_HOLD    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;
  localparam logic [31:0] NOP_INSTRUCTION = 32'd0;
  localparam int DEFAULT_PC_STEP = 4;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register; priority flush > hold > load, otherwise a bubble.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_Load,
  input  logic                   i_Hold,
  input  logic                   i_Flush,
  input  logic [ADDR_WIDTH-1:0]  i_PC,
  input  logic [INSTR_WIDTH-1:0] i_Instruction,
  output logic [ADDR_WIDTH-1:0]  o_PC,
  output logic [INSTR_WIDTH-1:0] o_Instruction,
  output logic                   o_Valid
);
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (i_Flush) begin
      r_instr <= INSTR_WIDTH'(NOP_INSTRUCTION);
      r_valid <= 1'b0;
    end else if (!i_Hold) begin
      if (i_Load) begin
        r_pc    <= i_PC;
        r_instr <= i_Instruction;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end
  assign o_PC          = r_pc;
  assign o_Instruction = r_instr;
  assign o_Valid       = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, variable-latency imem handshake and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = DEFAULT_PC_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_Sig_Hazard_Detected,
  input  logic                   i_Sig_Branch_Taken,
  input  logic [ADDR_WIDTH-1:0]  i_Branch_Address,
  output logic                   o_Imem_Req,
  output logic [ADDR_WIDTH-1:0]  o_Imem_Address,
  input  logic                   i_Imem_Ready,
  input  logic [INSTR_WIDTH-1:0] i_Imem_Data,
  output logic [ADDR_WIDTH-1:0]  o_IF_ID_PC,
  output logic [INSTR_WIDTH-1:0] o_IF_ID_Instruction,
  output logic                   o_IF_ID_Valid,
  output logic                   o_Sig_Fetch_Busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            o_Fetch_Count,
  output logic [31:0]            o_Stall_Count
`endif
);
  fetch_state_t           r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_redirect;
  logic [INSTR_WIDTH-1:0] r_hold;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic                   w_load;
  assign w_pc_next        = r_pc + ADDR_WIDTH'(PC_STEP);
  // Gated by reset so the request is low throughout reset and rises right after release.
  assign o_Imem_Req       = reset && (r_state != FS_HOLD);
  assign o_Imem_Address   = r_pc;
  assign o_Sig_Fetch_Busy = o_Imem_Req;
  assign w_load = !i_Sig_Hazard_Detected &&
                  (r_state == FS_HOLD || (r_state == FS_FETCH && i_Imem_Ready));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FS_FETCH;
      r_pc       <= '0;
      r_redirect <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        FS_FETCH:
          if (i_Sig_Branch_Taken) begin
            if (i_Imem_Ready) r_pc <= i_Branch_Address;
            else begin
              r_redirect <= i_Branch_Address;
              r_state    <= FS_DISCARD;
            end
          end else if (i_Imem_Ready) begin
            if (i_Sig_Hazard_Detected) begin
              r_hold  <= i_Imem_Data;
              r_state <= FS_HOLD;
            end else r_pc <= w_pc_next;
          end
        FS_HOLD:
          if (i_Sig_Branch_Taken) begin
            r_pc    <= i_Branch_Address;
            r_state <= FS_FETCH;
          end else if (!i_Sig_Hazard_Detected) begin
            r_pc    <= w_pc_next;
            r_state <= FS_FETCH;
          end
        FS_DISCARD:
          if (i_Imem_Ready) begin
            r_pc    <= i_Sig_Branch_Taken ? i_Branch_Address : r_redirect;
            r_state <= FS_FETCH;
          end else if (i_Sig_Branch_Taken) r_redirect <= i_Branch_Address;
        default: r_state <= FS_FETCH;
      endcase
    end
  end
  if_id_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .i_Load       (w_load),
    .i_Hold       (i_Sig_Hazard_Detected),
    .i_Flush      (i_Sig_Branch_Taken),
    .i_PC         (w_pc_next),
    .i_Instruction(r_state == FS_HOLD ? r_hold : i_Imem_Data),
    .o_PC         (o_IF_ID_PC),
    .o_Instruction(o_IF_ID_Instruction),
    .o_Valid      (o_IF_ID_Valid)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load && !i_Sig_Branch_Taken && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((i_Sig_Hazard_Detected || (r_state == FS_FETCH && !i_Imem_Ready)) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
  assign o_Fetch_Count = r_fetch_cnt;
  assign o_Stall_Count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage; checks perf counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0, haz = 1'b0, br = 1'b0, rdy = 1'b0;
  logic [31:0] br_addr = '0, data = '0;
  logic req, busy, valid;
  logic [31:0] addr, id_pc, id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, scnt;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                  (clk),
    .reset                (rst_n),
    .i_Sig_Hazard_Detected(haz),
    .i_Sig_Branch_Taken   (br),
    .i_Branch_Address     (br_addr),
    .o_Imem_Req           (req),
    .o_Imem_Address       (addr),
    .i_Imem_Ready         (rdy),
    .i_Imem_Data          (data),
    .o_IF_ID_PC           (id_pc),
    .o_IF_ID_Instruction  (id_instr),
    .o_IF_ID_Valid        (valid),
    .o_Sig_Fetch_Busy     (busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_Fetch_Count        (fcnt),
    .o_Stall_Count        (scnt)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; haz = 1'b0; br = 1'b0; rdy = 1'b0; br_addr = '0; data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({valid, id_pc, id_instr} !== 65'd0) begin errors++; $display("FAIL reset_ifid got %b/%h/%h want 0/0/0", valid, id_pc, id_instr); end
    rst_n = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'd0) begin errors++; $display("FAIL release_req got %b@%h want 1@0", req, addr); end
    data = word(0); rdy = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || id_pc !== 32'd4) begin errors++; $display("FAIL first_fetch got %b/%h want 1/4", valid, id_pc); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req, valid, id_pc} !== 34'd0) begin errors++; $display("FAIL async_reset got %b/%b/%h want 0/0/0", req, valid, id_pc); end
  endtask

  task automatic test_zero_wait;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr !== 32'(i * 4)) begin errors++; $display("FAIL zw_addr%0d got %h want %h", i, addr, i * 4); end
      data = word(32'(i * 4)); rdy = 1'b1;
      tick();
      checks++; if (valid !== 1'b1 || id_pc !== 32'(i * 4 + 4) || id_instr !== word(32'(i * 4)))
        begin errors++; $display("FAIL zw_ifid%0d got %b/%h/%h want 1/%h/%h", i, valid, id_pc, id_instr, i * 4 + 4, word(32'(i * 4))); end
    end
    rdy = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || id_pc !== 32'd16 || addr !== 32'd16) begin errors++; $display("FAIL zw_bubble got %b/%h/%h want 0/10/10", valid, id_pc, addr); end
  endtask

  task automatic test_latency;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (valid !== 1'b0 || addr !== 32'd0 || req !== 1'b1) begin errors++; $display("FAIL lat_wait%0d got %b/%h/%b want 0/0/1", i, valid, addr, req); end
    end
    data = word(0); rdy = 1'b1;
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'd4, word(0)}) begin errors++; $display("FAIL lat_load got %b/%h/%h want 1/4/%h", valid, id_pc, id_instr, word(0)); end
    checks++; if (addr !== 32'd4) begin errors++; $display("FAIL lat_pc got %h want 4", addr); end
  endtask

  task automatic test_hazard;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      data = word(32'(i * 4)); rdy = 1'b1;
      tick();
    end
    checks++; if (addr !== 32'd8) begin errors++; $display("FAIL hz_addr got %h want 8", addr); end
    data = word(8); haz = 1'b1;
    tick();
    checks++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hz_hold_req got %b/%b want 0/0", req, busy); end
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'd8, word(4)}) begin errors++; $display("FAIL hz_frozen1 got %b/%h/%h want 1/8/%h", valid, id_pc, id_instr, word(4)); end
    rdy = 1'b0;
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'd8, word(4)}) begin errors++; $display("FAIL hz_frozen2 got %b/%h/%h want 1/8/%h", valid, id_pc, id_instr, word(4)); end
    haz = 1'b0;
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'd12, word(8)}) begin errors++; $display("FAIL hz_release got %b/%h/%h want 1/c/%h", valid, id_pc, id_instr, word(8)); end
    checks++; if (req !== 1'b1 || addr !== 32'd12) begin errors++; $display("FAIL hz_next got %b@%h want 1@c", req, addr); end
  endtask

  task automatic test_discard;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      data = word(32'(i * 4)); rdy = 1'b1;
      tick();
    end
    checks++; if (addr !== 32'h20) begin errors++; $display("FAIL dc_addr got %h want 20", addr); end
    rdy = 1'b0; br = 1'b1; br_addr = 32'h100;
    tick();
    checks++; if (valid !== 1'b0 || id_instr !== 32'd0) begin errors++; $display("FAIL dc_flush got %b/%h want 0/0", valid, id_instr); end
    checks++; if (req !== 1'b1 || addr !== 32'h20) begin errors++; $display("FAIL dc_old_addr got %b@%h want 1@20", req, addr); end
    br = 1'b0; rdy = 1'b1; data = word(32'h20);
    tick();
    checks++; if (valid !== 1'b0 || addr !== 32'h100) begin errors++; $display("FAIL dc_drop got %b@%h want 0@100", valid, addr); end
    data = word(32'h100);
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'h104, word(32'h100)}) begin errors++; $display("FAIL dc_target got %b/%h/%h want 1/104/%h", valid, id_pc, id_instr, word(32'h100)); end
    rdy = 1'b0; br = 1'b1; br_addr = 32'h300;
    tick();
    br_addr = 32'h400;
    tick();
    checks++; if (addr !== 32'h104) begin errors++; $display("FAIL dc_stable got %h want 104", addr); end
    br = 1'b0; rdy = 1'b1; data = word(32'h104);
    tick();
    checks++; if (addr !== 32'h400 || valid !== 1'b0) begin errors++; $display("FAIL dc_youngest got %h/%b want 400/0", addr, valid); end
  endtask

  task automatic test_branch_in_hold;
    apply_reset();
    data = word(0); rdy = 1'b1;
    tick();
    data = word(4); haz = 1'b1;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL bh_hold got %b want 0", req); end
    rdy = 1'b0; br = 1'b1; br_addr = 32'h80;
    tick();
    checks++; if (valid !== 1'b0 || id_instr !== 32'd0) begin errors++; $display("FAIL bh_flush got %b/%h want 0/0", valid, id_instr); end
    checks++; if (req !== 1'b1 || addr !== 32'h80) begin errors++; $display("FAIL bh_target got %b@%h want 1@80", req, addr); end
    br = 1'b0; haz = 1'b0; rdy = 1'b1; data = word(32'h80);
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'h84, word(32'h80)}) begin errors++; $display("FAIL bh_after got %b/%h/%h want 1/84/%h", valid, id_pc, id_instr, word(32'h80)); end
  endtask

  task automatic test_wrap;
    apply_reset();
    br = 1'b1; br_addr = 32'hFFFF_FFFC; rdy = 1'b1; data = word(0);
    tick();
    checks++; if (addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin errors++; $display("FAIL wr_branch got %h/%b want fffffffc/0", addr, valid); end
    br = 1'b0; data = word(32'hFFFF_FFFC);
    tick();
    checks++; if ({valid, id_pc, id_instr} !== {1'b1, 32'd0, word(32'hFFFF_FFFC)}) begin errors++; $display("FAIL wr_ifid got %b/%h/%h want 1/0/%h", valid, id_pc, id_instr, word(32'hFFFF_FFFC)); end
    checks++; if (addr !== 32'd0) begin errors++; $display("FAIL wr_addr got %h want 0", addr); end
    data = word(0);
    tick();
    checks++; if (id_pc !== 32'd4 || valid !== 1'b1) begin errors++; $display("FAIL wr_next got %h/%b want 4/1", id_pc, valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fcnt !== 32'd2) begin errors++; $display("FAIL perf_fetch got %0d want 2", fcnt); end
    checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL perf_stall got %0d want 0", scnt); end
    rdy = 1'b0;
    tick();
    tick();
    checks++; if (scnt !== 32'd2 || fcnt !== 32'd2) begin errors++; $display("FAIL perf_stall2 got %0d/%0d want 2/2", scnt, fcnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_hazard();
    test_discard();
    test_branch_in_hold();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
